id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_if.sv | 64 ++++++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// ID/EX pipeline boundary bundle: decoded instruction from ID, MEM/WB forwarding
// sources, pipeline control, and the registered/forwarded EX-side outputs.
interface id_ex_if;
  // ID-stage instruction
  logic        valid_id;
  logic [31:0] pc_id;
  logic [31:0] rD1_id;
  logic [31:0] rD2_id;
  logic [31:0] imm_id;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rd_id;
  logic        use_rs1_id;
  logic        use_rs2_id;
  logic [3:0]  alu_op_id;
  logic        alu_bsel_id;
  logic        reg_we_id;
  logic        mem_rd_id;
  logic        mem_we_id;
  logic        branch_id;
  // Forwarding sources
  logic [4:0]  rd_mem;
  logic        reg_we_mem;
  logic        mem_rd_mem;
  logic [31:0] alu_c_mem;
  logic [4:0]  rd_wb;
  logic        reg_we_wb;
  logic [31:0] wD_wb;
  // Pipeline control
  logic        flush_ex;
  logic        hold_ext;
  // EX-side outputs
  logic [31:0] rD1_ex;
  logic [31:0] alu_b_ex;
  logic [3:0]  alu_op_ex;
  logic [31:0] rD2_ex;
  logic [31:0] pc_ex;
  logic [31:0] imm_ex;
  logic [4:0]  rd_ex;
  logic        valid_ex;
  logic        reg_we_ex;
  logic        mem_rd_ex;
  logic        mem_we_ex;
  logic        branch_ex;
  logic        stall_id;

  modport master (
    output valid_id, pc_id, rD1_id, rD2_id, imm_id, rs1_id, rs2_id, rd_id,
           use_rs1_id, use_rs2_id, alu_op_id, alu_bsel_id, reg_we_id, mem_rd_id,
           mem_we_id, branch_id, rd_mem, reg_we_mem, mem_rd_mem, alu_c_mem,
           rd_wb, reg_we_wb, wD_wb, flush_ex, hold_ext,
    input  rD1_ex, alu_b_ex, alu_op_ex, rD2_ex, pc_ex, imm_ex, rd_ex, valid_ex,
           reg_we_ex, mem_rd_ex, mem_we_ex, branch_ex, stall_id
  );

  modport slave (
    input  valid_id, pc_id, rD1_id, rD2_id, imm_id, rs1_id, rs2_id, rd_id,
           use_rs1_id, use_rs2_id, alu_op_id, alu_bsel_id, reg_we_id, mem_rd_id,
           mem_we_id, branch_id, rd_mem, reg_we_mem, mem_rd_mem, alu_c_mem,
           rd_wb, reg_we_wb, wD_wb, flush_ex, hold_ext,
    output rD1_ex, alu_b_ex, alu_op_ex, rD2_ex, pc_ex, imm_ex, rd_ex, valid_ex,
           reg_we_ex, mem_rd_ex, mem_we_ex, branch_ex, stall_id
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and MEM/WB operand
// forwarding. Forwarding is purely combinational off the registered EX fields.
module id_ex_stage (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_bsel;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_we;
    logic        branch;
  } ex_reg_t;

  // A bubble is the all-zero record, so '0 serves for reset, flush and stall.
  ex_reg_t ex_q, ex_d, id_rec;
  logic    hazard;
  logic [31:0] rs1_val, rs2_val;

  // MEM (non-load results only) beats WB; index 0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [31:0] reg_val,
    input logic [4:0]  rd_mem,
    input logic        we_mem,
    input logic        rd_mem_load,
    input logic [31:0] c_mem,
    input logic [4:0]  rd_wb,
    input logic        we_wb,
    input logic [31:0] d_wb
  );
    logic [31:0] val;
    val = reg_val;
    if (we_mem && !rd_mem_load && rd_mem != 5'd0 && rd_mem == rs) begin
      val = c_mem;
    end else if (we_wb && rd_wb != 5'd0 && rd_wb == rs) begin
      val = d_wb;
    end
    return val;
  endfunction

  // Pack the ID fields into the EX record layout.
  always_comb begin
    id_rec          = '0;
    id_rec.valid    = 1'b1;
    id_rec.pc       = bus.pc_id;
    id_rec.rd1      = bus.rD1_id;
    id_rec.rd2      = bus.rD2_id;
    id_rec.imm      = bus.imm_id;
    id_rec.rs1      = bus.rs1_id;
    id_rec.rs2      = bus.rs2_id;
    id_rec.rd       = bus.rd_id;
    id_rec.alu_op   = bus.alu_op_id;
    id_rec.alu_bsel = bus.alu_bsel_id;
    id_rec.reg_we   = bus.reg_we_id;
    id_rec.mem_rd   = bus.mem_rd_id;
    id_rec.mem_we   = bus.mem_we_id;
    id_rec.branch   = bus.branch_id;
  end

  // Load-use detection against the load currently sitting in EX.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_rd && (ex_q.rd != 5'd0) && bus.valid_id &&
             ((bus.use_rs1_id && bus.rs1_id == ex_q.rd) ||
              (bus.use_rs2_id && bus.rs2_id == ex_q.rd));
    // Hold freezes upstream on its own, and a flush kills the load's consumer.
    bus.stall_id = rst_n && hazard && !bus.flush_ex && !bus.hold_ext;
  end

  // Next EX record: flush > hold > load-use bubble > load from ID.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush_ex) begin
      ex_d = '0;
    end else if (bus.hold_ext) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
    end else if (!bus.valid_id) begin
      ex_d = '0;
    end else begin
      ex_d = id_rec;
    end
  end

  // EX register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarded operands and registered outputs.
  always_comb begin
    rs1_val = ex_q.rd1;
    rs2_val = ex_q.rd2;
    if (ex_q.valid) begin
      rs1_val = fwd_sel(ex_q.rs1, ex_q.rd1, bus.rd_mem, bus.reg_we_mem, bus.mem_rd_mem,
                        bus.alu_c_mem, bus.rd_wb, bus.reg_we_wb, bus.wD_wb);
      rs2_val = fwd_sel(ex_q.rs2, ex_q.rd2, bus.rd_mem, bus.reg_we_mem, bus.mem_rd_mem,
                        bus.alu_c_mem, bus.rd_wb, bus.reg_we_wb, bus.wD_wb);
    end
    bus.rD1_ex    = rs1_val;
    bus.rD2_ex    = rs2_val;
    bus.alu_b_ex  = ex_q.alu_bsel ? ex_q.imm : rs2_val;
    bus.alu_op_ex = ex_q.alu_op;
    bus.pc_ex     = ex_q.pc;
    bus.imm_ex    = ex_q.imm;
    bus.rd_ex     = ex_q.rd;
    bus.valid_ex  = ex_q.valid;
    bus.reg_we_ex = ex_q.reg_we;
    bus.mem_rd_ex = ex_q.mem_rd;
    bus.mem_we_ex = ex_q.mem_we;
    bus.branch_ex = ex_q.branch;
  end

endmodule
